// File: rtl/alu_chain_seq.sv
// Multi-cycle ALU that chains WIDTH/4 mc10181-style 4-bit groups, GPC per clock.
// Latency: an operation accepted at edge T shows out_valid after edge T+NCYC.
// Backpressure: f/cout/zero hold in DONE until out_ready; in_ready follows out_ready there.
//
// Ports:
//   clk, reset      sole clock, synchronous active-high reset
//   s[0:3], boole   function select and logic(1)/arithmetic(0) mode
//   cin             carry into the least-significant group
//   a, b            operands, bit 0 is the MSB
//   in_valid/ready  request handshake
//   f, cout, zero   registered result, carry out of group 0, f==0 flag
//   out_valid/ready result handshake
module alu_chain_seq #(
  parameter int WIDTH = 36,
  parameter int GPC   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:3]       s,
  input  logic             boole,
  input  logic             cin,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:WIDTH-1] f,
  output logic             cout,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NG   = WIDTH / 4;
  localparam int NCYC = NG / GPC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int WW   = 4 * GPC;
  localparam logic [WIDTH-1:0] MASK = WIDTH'({WW{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic              accept, last_step;
  logic [CW-1:0]     step;
  logic              carry;
  logic [3:0]        s_q;
  logic              boole_q;
  // Stored with the natural [MSB:0] numbering so that bit 0 is the LSB;
  // assigning from the [0:W-1] ports keeps the numeric value.
  logic [WIDTH-1:0]  a_q, b_q, f_q;
  logic [WW-1:0]     wa, wb, wf;
  logic [GPC-1:0]    gcg, gcp;
  logic [GPC:0]      gc;
  logic [WIDTH-1:0]  f_nxt;
  int                sh;

  // Per-bit propagate/generate of the mc10181 cell; sl = {S3,S2,S1,S0}.
  // g implies p, so carry = g | p&c and the half-sum is p^g.
  function automatic logic [7:0] bit_pg(input logic [3:0] ga, input logic [3:0] gb,
                                        input logic [3:0] sl);
    logic [3:0] p, g;
    for (int i = 0; i < 4; i++) begin
      p[i] = ga[i] | (gb[i] & sl[0]) | (~gb[i] & sl[1]);
      g[i] = (ga[i] & ~gb[i] & sl[2]) | (ga[i] & gb[i] & sl[3]);
    end
    return {p, g};
  endfunction

  // Group carry-generate / carry-propagate, independent of carry-in.
  function automatic logic [1:0] grp_gp(input logic [3:0] ga, input logic [3:0] gb,
                                        input logic [3:0] sl);
    logic [7:0] pg;
    logic [3:0] p, g;
    pg = bit_pg(ga, gb, sl);
    p  = pg[7:4];
    g  = pg[3:0];
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
  endfunction

  // Group result; logic mode ignores the carry entirely.
  function automatic logic [3:0] grp_f(input logic [3:0] ga, input logic [3:0] gb,
                                       input logic [3:0] sl, input logic lg, input logic gcin);
    logic [7:0] pg;
    logic [3:0] p, g, fo;
    logic       c;
    pg = bit_pg(ga, gb, sl);
    p  = pg[7:4];
    g  = pg[3:0];
    c  = gcin;
    for (int i = 0; i < 4; i++) begin
      fo[i] = lg ? ~(p[i] ^ g[i]) : (p[i] ^ g[i] ^ c);
      c     = g[i] | (p[i] & c);
    end
    return fo;
  endfunction

  // Window evaluation for the current step: group 0 of the window is the
  // least-significant one and takes the held carry.
  always_comb begin
    sh    = WW * int'(step);
    wa    = WW'(a_q >> sh);
    wb    = WW'(b_q >> sh);
    gcg   = '0;
    gcp   = '0;
    gc    = '0;
    wf    = '0;
    for (int j = 0; j < GPC; j++) begin
      {gcg[j], gcp[j]} = grp_gp(wa[4*j +: 4], wb[4*j +: 4], s_q);
    end
    // Flat lookahead: carry into group j is a sum of products of cg/cp terms,
    // so no group's carry-out feeds the next group's carry-in.
    gc[0] = carry;
    for (int j = 1; j <= GPC; j++) begin
      logic c_or, t;
      c_or = 1'b0;
      for (int m = 0; m < j; m++) begin
        t = gcg[m];
        for (int n = m + 1; n < j; n++) t = t & gcp[n];
        c_or = c_or | t;
      end
      t = carry;
      for (int n = 0; n < j; n++) t = t & gcp[n];
      gc[j] = c_or | t;
    end
    for (int j = 0; j < GPC; j++) begin
      wf[4*j +: 4] = grp_f(wa[4*j +: 4], wb[4*j +: 4], s_q, boole_q, gc[j]);
    end
    f_nxt = (f_q & ~(MASK << sh)) | (WIDTH'(wf) << sh);
  end

  assign last_step = (step == CW'(NCYC - 1));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign f         = f_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        // Releasing the result and taking the next request share one edge.
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      boole_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      carry   <= 1'b0;
      step    <= '0;
      cout    <= 1'b0;
      zero    <= 1'b1;
    end else if (accept) begin
      // f, cout and zero keep the previous result until overwritten.
      s_q     <= s;
      boole_q <= boole;
      a_q     <= a;
      b_q     <= b;
      carry   <= cin;
      step    <= '0;
    end else if (state == RUN) begin
      f_q   <= f_nxt;
      carry <= gc[GPC];
      step  <= step + 1'b1;
      if (last_step) begin
        cout <= gc[GPC];
        zero <= (f_nxt == '0);
      end
    end
  end

endmodule

// File: doc/alu_chain_seq.md
ALU_CHAIN_SEQ -- requirements
Module: alu_chain_seq

Interface
REQ-001 Parameter WIDTH, default 36: operand width in bits; SHALL be a multiple of 4; NG = WIDTH/4 groups.
REQ-002 Parameter GPC, default 9: groups evaluated per clock; SHALL divide NG; NCYC = NG/GPC.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s  input  [0:3]  function select, mc10181 encoding.
REQ-006 boole  input  1  1 = logic mode, 0 = arithmetic mode.
REQ-007 cin  input  1  carry into least-significant group, active-high.
REQ-008 a, b  input  [0:WIDTH-1]  operands; bit 0 is MSB.
REQ-009 in_valid / in_ready  input / output  1  operation request handshake.
REQ-010 f  output  [0:WIDTH-1]  registered result.
REQ-011 cout  output  1  carry out of most-significant group (group 0).
REQ-012 zero  output  1  1 when f is all zeros.
REQ-013 out_valid / out_ready  output / input  1  result handshake.

Function
REQ-014 Each 4-bit group g (bits 4g..4g+3) SHALL produce f, group carry-out, cg and cp bit-identically to mc10181 for the same s, boole, group carry-in.
REQ-015 The carry chain SHALL run from group NG-1 (LSB) to group 0; group NG-1 takes cin; in logic mode f SHALL be independent of carry, but cout SHALL still follow mc10181 group carry semantics.
REQ-016 Within a cycle, the GPC groups SHALL be chained by lookahead from cg/cp, not by ripple through the groups' cout.
REQ-017 States: IDLE, RUN, DONE.
REQ-018 in_ready = 1 in IDLE, and in DONE while out_ready = 1; otherwise 0.
REQ-019 Accept = in_valid & in_ready; on accept, s, boole, a, b and cin SHALL be latched, the step counter cleared, and the state set to RUN.
REQ-020 RUN step k (k = 0..NCYC-1) SHALL evaluate groups NG-1-k*GPC down to NG-(k+1)*GPC, using the held carry as carry-in.
REQ-021 In RUN step k, the result bits of those groups SHALL be written into the f register and their carry-out stored in the carry flop.
REQ-022 Input changes after accept SHALL NOT affect the operation in progress.
REQ-023 After step NCYC-1: cout = final carry, zero computed from the completed f, state set to DONE, out_valid = 1.
REQ-024 Latency: accept at edge T gives out_valid high after edge T+NCYC; default parameters give 1-cycle latency.
REQ-025 out_valid SHALL be 1 only in DONE; f, cout and zero SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-026 In DONE with out_ready = 1 and in_valid = 0, the state SHALL return to IDLE.
REQ-027 In DONE with out_ready = 1 and in_valid = 1, the new operation SHALL be accepted in the same cycle and the state set to RUN (back-to-back, no bubble); f retains old value until overwritten by step 0.
REQ-028 Throughput SHALL be one operation per NCYC+1 cycles sustained; no operation is dropped or duplicated.

Reset
REQ-029 reset = 1 at a clock edge SHALL force IDLE, out_valid = 0, f = 0, cout = 0, zero = 1, carry flop = 0, step counter = 0, and in_ready = 1 the following cycle.
REQ-030 reset SHALL take priority over every handshake; an operation in RUN or DONE is discarded without producing a result.
REQ-031 in_valid asserted in the same cycle as reset SHALL NOT be accepted.

Verification
REQ-032 Logic mode, default parameters: s = 0000, boole = 1, cin = 0, a = 36'hF0F0F0F0F, b = 0 -> one cycle later f = 36'h0F0F0F0F0, out_valid = 1.
REQ-033 Add, default parameters: s = 1001, boole = 0, cin = 0, a = 36'hFFFFFFFFF, b = 1 -> f = 0, cout = 1, zero = 1.
REQ-034 Subtract, WIDTH = 36, GPC = 1 (NCYC = 9): s = 0110, boole = 0, cin = 1, a = 5, b = 3 -> out_valid exactly 9 cycles after accept, f = 2, cout = 1.
REQ-035 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> f, cout and out_valid are unchanged and in_ready = 0; then out_ready = 1 with in_valid = 1 -> accepted that same edge.
REQ-036 Reset mid-RUN (GPC = 1, reset at step 4) -> next cycle IDLE, out_valid = 0, f = 0, zero = 1; no result is ever presented for the aborted operation.
REQ-037 Randomised comparison: 10k operations across all 32 s/boole codes, random cin and random out_ready, compared against a chain of NG mc10181 instances -> zero mismatches for GPC in {1, 3, 9}.
